// File: rtl/pxl_raster_tx_if.sv
// Pixel stream carrying one pixel per handshake plus the frame geometry.
// The master side is the producer and the slave side is the consumer (e.g. the image resizer input).
interface pxl_raster_tx_if #(
   parameter int PXL_PRIM_COLOR_W   = 8,
   parameter int PXL_PRIM_COLOR_NUM = 3,
   parameter int IMG_WIDTH_IDX_W    = 11,
   parameter int IMG_HEIGHT_IDX_W   = 10
);
   logic [PXL_PRIM_COLOR_W-1:0] PxlData [PXL_PRIM_COLOR_NUM];
   logic [IMG_WIDTH_IDX_W-1:0]  PxlX;
   logic [IMG_HEIGHT_IDX_W-1:0] PxlY;
   logic [IMG_WIDTH_IDX_W-1:0]  ImgWidth;
   logic [IMG_HEIGHT_IDX_W-1:0] ImgHeight;
   logic                        PxlVld;
   logic                        PxlRdy;

   modport master (
      output PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld,
      input  PxlRdy
   );

   modport slave (
      input  PxlData, PxlX, PxlY, ImgWidth, ImgHeight, PxlVld,
      output PxlRdy
   );
endinterface

// File: rtl/pxl_raster_tx.sv
// Raster-scan pixel transmitter: streams a stored frame from a 1-cycle-latency memory
// through a 2-entry prefetch buffer so the output can sustain one pixel per cycle.
module pxl_raster_tx #(
   parameter int PXL_PRIM_COLOR_W   = 8,
   parameter int PXL_PRIM_COLOR_NUM = 3,
   parameter int IMG_WIDTH_IDX_W    = 11,
   parameter int IMG_HEIGHT_IDX_W   = 10,
   parameter int MEM_ADDR_W         = 21
) (
   input  logic                                         Clk,
   input  logic                                         Reset,
   input  logic                                         Start,
   input  logic [IMG_WIDTH_IDX_W-1:0]                   CfgWidth,
   input  logic [IMG_HEIGHT_IDX_W-1:0]                  CfgHeight,
   input  logic [MEM_ADDR_W-1:0]                        CfgBaseAddr,
   output logic                                         Busy,
   output logic                                         Done,
   output logic                                         MemRdEn,
   output logic [MEM_ADDR_W-1:0]                        MemRdAddr,
   input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] MemRdData,
   pxl_raster_tx_if.master                              Pxl
);
   localparam int DataW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;

   typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

   stateT                       state, stateNxt;
   logic [IMG_WIDTH_IDX_W-1:0]  latWidth, lastX, rdX, outX;
   logic [IMG_HEIGHT_IDX_W-1:0] latHeight, lastY, rdY, outY;
   logic [MEM_ADDR_W-1:0]       rdAddr;
   logic                        rdActive, rdInFlight;
   logic [DataW-1:0]            bufMem [2];
   logic [DataW-1:0]            bufHead;
   logic                        bufWrPtr, bufRdPtr;
   logic [1:0]                  bufCnt, occTotal;
   logic                        startAcc, pop, lastPxl, creditOk;

   assign startAcc = (state == StIdle) && Start;
   assign lastX    = latWidth - IMG_WIDTH_IDX_W'(1);
   assign lastY    = latHeight - IMG_HEIGHT_IDX_W'(1);
   assign pop      = Pxl.PxlVld && Pxl.PxlRdy;
   assign lastPxl  = (outX == lastX) && (outY == lastY);
   // Buffered plus in-flight words never exceed two; a same-cycle pop frees the slot the new read needs.
   assign occTotal = bufCnt + {1'b0, rdInFlight};
   assign creditOk = (occTotal < 2'd2) || ((occTotal == 2'd2) && pop);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= StIdle;
      else        state <= stateNxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      stateNxt = state;
      Busy     = 1'b0;
      Done     = 1'b0;
      MemRdEn  = 1'b0;
      unique case (state)
         StIdle: begin
            if (Start)
               stateNxt = ((CfgWidth == '0) || (CfgHeight == '0)) ? StDone : StRun;
         end
         StRun: begin
            Busy    = 1'b1;
            MemRdEn = rdActive && creditOk;
            if (pop && lastPxl) stateNxt = StDone;
         end
         StDone: begin
            Busy     = 1'b1;
            Done     = 1'b1;
            stateNxt = StIdle;
         end
         default: stateNxt = StIdle;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         latWidth  <= '0;
         latHeight <= '0;
         rdX       <= '0;
         rdY       <= '0;
         rdAddr    <= '0;
         rdActive  <= 1'b0;
         outX      <= '0;
         outY      <= '0;
      end else if (startAcc) begin
         latWidth  <= CfgWidth;
         latHeight <= CfgHeight;
         rdX       <= '0;
         rdY       <= '0;
         rdAddr    <= CfgBaseAddr;
         rdActive  <= (CfgWidth != '0) && (CfgHeight != '0);
         outX      <= '0;
         outY      <= '0;
      end else begin
         if (MemRdEn) begin
            rdAddr <= rdAddr + MEM_ADDR_W'(1);
            if (rdX == lastX) begin
               rdX <= '0;
               if (rdY == lastY) rdActive <= 1'b0;
               else              rdY      <= rdY + IMG_HEIGHT_IDX_W'(1);
            end else begin
               rdX <= rdX + IMG_WIDTH_IDX_W'(1);
            end
         end
         if (pop) begin
            if (outX == lastX) begin
               outX <= '0;
               outY <= lastPxl ? '0 : outY + IMG_HEIGHT_IDX_W'(1);
            end else begin
               outX <= outX + IMG_WIDTH_IDX_W'(1);
            end
         end
      end
   end

   // NOTE: the two buffer words are reset because PxlData must read zero while in reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bufMem[0]  <= '0;
         bufMem[1]  <= '0;
         bufWrPtr   <= 1'b0;
         bufRdPtr   <= 1'b0;
         bufCnt     <= '0;
         rdInFlight <= 1'b0;
      end else begin
         rdInFlight <= MemRdEn;
         if (rdInFlight) begin
            bufMem[bufWrPtr] <= MemRdData;
            bufWrPtr         <= ~bufWrPtr;
         end
         if (pop) bufRdPtr <= ~bufRdPtr;
         bufCnt <= bufCnt + {1'b0, rdInFlight} - {1'b0, pop};
      end
   end

   assign MemRdAddr     = rdAddr;
   assign Pxl.ImgWidth  = latWidth;
   assign Pxl.ImgHeight = latHeight;
   assign Pxl.PxlX      = outX;
   assign Pxl.PxlY      = outY;
   assign Pxl.PxlVld    = (bufCnt != 2'd0);

   always_comb begin
      bufHead = bufMem[bufRdPtr];
      for (int i = 0; i < PXL_PRIM_COLOR_NUM; i++)
         Pxl.PxlData[i] = bufHead[i*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W];
   end
endmodule

// File: tb/tb_pxl_raster_tx.sv
// Self-checking bench for pxl_raster_tx: randomized back-pressure against a frame-level
// reference model (pixel index -> column, row, address, memory word).
module tb_pxl_raster_tx;
   localparam int CW  = 8;
   localparam int NUM = 3;
   localparam int IW  = 11;
   localparam int HW  = 10;
   localparam int AW  = 21;
   localparam int DW  = CW * NUM;

   logic          Clk;
   logic          Reset;
   logic          Start;
   logic [IW-1:0] CfgWidth;
   logic [HW-1:0] CfgHeight;
   logic [AW-1:0] CfgBaseAddr;
   logic          Busy;
   logic          Done;
   logic          MemRdEn;
   logic [AW-1:0] MemRdAddr;
   logic [DW-1:0] MemRdData;

   int checks   = 0;
   int failures = 0;

   pxl_raster_tx_if #(
      .PXL_PRIM_COLOR_W(CW), .PXL_PRIM_COLOR_NUM(NUM),
      .IMG_WIDTH_IDX_W(IW), .IMG_HEIGHT_IDX_W(HW)
   ) pxl ();

   pxl_raster_tx #(
      .PXL_PRIM_COLOR_W(CW), .PXL_PRIM_COLOR_NUM(NUM),
      .IMG_WIDTH_IDX_W(IW), .IMG_HEIGHT_IDX_W(HW), .MEM_ADDR_W(AW)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .CfgWidth(CfgWidth), .CfgHeight(CfgHeight), .CfgBaseAddr(CfgBaseAddr),
      .Busy(Busy), .Done(Done),
      .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
      .Pxl(pxl)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Pixel memory: each word holds its own address, returned one cycle after the request.
   always @(posedge Clk) begin
      if (MemRdEn) MemRdData <= {{(DW-AW){1'b0}}, MemRdAddr};
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   task automatic test_reset(input string name);
      Reset = 1'b0;
      #1;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || MemRdEn !== 1'b0 || MemRdAddr !== '0) begin
         failures++;
         $display("FAIL %s ctrl got Busy=%b Done=%b MemRdEn=%b MemRdAddr=%h required 0 0 0 0",
                  name, Busy, Done, MemRdEn, MemRdAddr);
      end
      checks++;
      if (pxl.PxlVld !== 1'b0 || pxl.PxlX !== '0 || pxl.PxlY !== '0 ||
          pxl.ImgWidth !== '0 || pxl.ImgHeight !== '0) begin
         failures++;
         $display("FAIL %s stream got Vld=%b X=%0d Y=%0d W=%0d H=%0d required all 0",
                  name, pxl.PxlVld, pxl.PxlX, pxl.PxlY, pxl.ImgWidth, pxl.ImgHeight);
      end
      for (int i = 0; i < NUM; i++) begin
         checks++;
         if (pxl.PxlData[i] !== '0) begin
            failures++;
            $display("FAIL %s PxlData[%0d] got=%h required=00", name, i, pxl.PxlData[i]);
         end
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
   endtask

   // Runs one frame; pixel k of the frame sits at column k%W, row k/W, address base+y*W+x.
   task automatic run_frame(input string name, input int w, input int h,
                            input logic [AW-1:0] base, input int rdyPct, input int restartCyc);
      int total, hs, rd, cyc, firstVld, lastHsCyc, vldCycles, budget, ex, ey;
      bit finished, prevStall, expDone;
      logic [CW-1:0] prevData [NUM];
      logic [IW-1:0] prevX;
      logic [HW-1:0] prevY;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWord;
      total = w * h; hs = 0; rd = 0; firstVld = -1; lastHsCyc = -1; vldCycles = 0;
      budget = total * 8 + 40; finished = 1'b0; prevStall = 1'b0;
      prevX = '0; prevY = '0;
      for (int i = 0; i < NUM; i++) prevData[i] = '0;

      @(negedge Clk);
      CfgWidth = IW'(w); CfgHeight = HW'(h); CfgBaseAddr = base; Start = 1'b1; PxlRdyDrive(1'b0);
      @(negedge Clk);
      Start = 1'b0;
      cyc = 1;
      while (!finished && cyc <= budget) begin
         if (cyc == restartCyc) begin
            Start = 1'b1; CfgWidth = IW'(w + 3); CfgHeight = HW'(h + 2); CfgBaseAddr = base + AW'(77);
         end else begin
            Start = 1'b0; CfgWidth = IW'(w); CfgHeight = HW'(h); CfgBaseAddr = base;
         end

         checks++;
         if (lastHsCyc >= 0 && cyc == lastHsCyc + 2) begin
            finished = 1'b1;
            if (Busy !== 1'b0 || Done !== 1'b0) begin
               failures++;
               $display("FAIL %s end_idle cyc%0d got Busy=%b Done=%b required 0 0", name, cyc, Busy, Done);
            end
         end else begin
            expDone = (lastHsCyc >= 0 && cyc == lastHsCyc + 1);
            if (Busy !== 1'b1 || Done !== expDone) begin
               failures++;
               $display("FAIL %s status cyc%0d got Busy=%b Done=%b required 1 %b", name, cyc, Busy, Done, expDone);
            end
         end
         checks++;
         if (pxl.ImgWidth !== IW'(w) || pxl.ImgHeight !== HW'(h)) begin
            failures++;
            $display("FAIL %s geometry cyc%0d got %0dx%0d required %0dx%0d",
                     name, cyc, pxl.ImgWidth, pxl.ImgHeight, w, h);
         end

         if (!finished) begin
            if (prevStall) begin
               checks++;
               if (pxl.PxlVld !== 1'b1 || pxl.PxlX !== prevX || pxl.PxlY !== prevY ||
                   pxl.PxlData[0] !== prevData[0] || pxl.PxlData[1] !== prevData[1] ||
                   pxl.PxlData[2] !== prevData[2]) begin
                  failures++;
                  $display("FAIL %s stall_hold cyc%0d got Vld=%b X=%0d Y=%0d required held X=%0d Y=%0d",
                           name, cyc, pxl.PxlVld, pxl.PxlX, pxl.PxlY, prevX, prevY);
               end
            end
            if (pxl.PxlVld === 1'b1) begin
               if (firstVld < 0) firstVld = cyc;
               vldCycles++;
               checks++;
               if (hs >= total) begin
                  failures++;
                  $display("FAIL %s extra_pixel cyc%0d got Vld=1 after %0d pixels required 0", name, cyc, total);
               end else begin
                  ex = hs % w;
                  ey = hs / w;
                  expAddr = base + AW'(ey * w + ex);
                  expWord = {{(DW-AW){1'b0}}, expAddr};
                  if (pxl.PxlX !== IW'(ex) || pxl.PxlY !== HW'(ey)) begin
                     failures++;
                     $display("FAIL %s pix%0d coord got (%0d,%0d) required (%0d,%0d)",
                              name, hs, pxl.PxlX, pxl.PxlY, ex, ey);
                  end
                  for (int i = 0; i < NUM; i++) begin
                     checks++;
                     if (pxl.PxlData[i] !== expWord[i*CW +: CW]) begin
                        failures++;
                        $display("FAIL %s pix%0d color%0d got=%h required=%h",
                                 name, hs, i, pxl.PxlData[i], expWord[i*CW +: CW]);
                     end
                  end
               end
            end

            PxlRdyDrive(int'($urandom_range(0, 99)) < rdyPct);
            #1;
            if (cyc == 1) begin
               checks++;
               if (MemRdEn !== 1'b1 || MemRdAddr !== base) begin
                  failures++;
                  $display("FAIL %s first_read got En=%b Addr=%h required 1 %h", name, MemRdEn, MemRdAddr, base);
               end
            end
            if (lastHsCyc >= 0) begin
               checks++;
               if (MemRdEn !== 1'b0) begin
                  failures++;
                  $display("FAIL %s read_in_done cyc%0d got MemRdEn=%b required 0", name, cyc, MemRdEn);
               end
            end
            if (MemRdEn === 1'b1) begin
               checks++;
               if (rd >= total || MemRdAddr !== base + AW'(rd)) begin
                  failures++;
                  $display("FAIL %s read%0d got Addr=%h required %h (frame has %0d reads)",
                           name, rd, MemRdAddr, base + AW'(rd), total);
               end
               rd++;
            end

            prevStall = (pxl.PxlVld === 1'b1) && !pxl.PxlRdy;
            prevX = pxl.PxlX;
            prevY = pxl.PxlY;
            for (int i = 0; i < NUM; i++) prevData[i] = pxl.PxlData[i];
            if (pxl.PxlVld === 1'b1 && pxl.PxlRdy) begin
               hs++;
               if (hs == total) lastHsCyc = cyc;
            end
            checks++;
            if (rd - hs > 2) begin
               failures++;
               $display("FAIL %s occupancy cyc%0d got %0d words outstanding required <=2", name, cyc, rd - hs);
            end
            @(negedge Clk);
            cyc++;
         end
      end
      Start = 1'b0;
      CfgWidth = IW'(w); CfgHeight = HW'(h); CfgBaseAddr = base;
      PxlRdyDrive(1'b0);

      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL %s timeout got %0d handshakes in %0d cycles required %0d", name, hs, budget, total);
      end
      checks++;
      if (hs != total || rd != total) begin
         failures++;
         $display("FAIL %s totals got pixels=%0d reads=%0d required %0d", name, hs, rd, total);
      end
      checks++;
      if (firstVld != 3) begin
         failures++;
         $display("FAIL %s latency got first PxlVld at cycle %0d required 3", name, firstVld);
      end
      if (rdyPct >= 100) begin
         checks++;
         if (vldCycles != total || lastHsCyc - firstVld + 1 != total) begin
            failures++;
            $display("FAIL %s back_to_back got %0d valid cycles spanning %0d required %0d",
                     name, vldCycles, lastHsCyc - firstVld + 1, total);
         end
      end
   endtask

   task automatic PxlRdyDrive(input logic v);
      pxl.PxlRdy = v;
   endtask

   task automatic test_zero_size(input string name, input int w, input int h);
      @(negedge Clk);
      CfgWidth = IW'(w); CfgHeight = HW'(h); CfgBaseAddr = AW'($urandom); Start = 1'b1;
      @(negedge Clk);
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b1 || MemRdEn !== 1'b0 || pxl.PxlVld !== 1'b0) begin
         failures++;
         $display("FAIL %s done_cycle got Done=%b Busy=%b MemRdEn=%b Vld=%b required 1 1 0 0",
                  name, Done, Busy, MemRdEn, pxl.PxlVld);
      end
      checks++;
      if (pxl.ImgWidth !== IW'(w) || pxl.ImgHeight !== HW'(h)) begin
         failures++;
         $display("FAIL %s geometry got %0dx%0d required %0dx%0d", name, pxl.ImgWidth, pxl.ImgHeight, w, h);
      end
      // A start pulse while DONE must be ignored.
      CfgWidth = IW'(9); CfgHeight = HW'(9);
      @(negedge Clk);
      Start = 1'b0;
      for (int c = 2; c <= 3; c++) begin
         checks++;
         if (Busy !== 1'b0 || Done !== 1'b0 || MemRdEn !== 1'b0 || pxl.PxlVld !== 1'b0 ||
             pxl.ImgWidth !== IW'(w)) begin
            failures++;
            $display("FAIL %s idle_cyc%0d got Busy=%b Done=%b MemRdEn=%b Vld=%b W=%0d required 0 0 0 0 %0d",
                     name, c, Busy, Done, MemRdEn, pxl.PxlVld, pxl.ImgWidth, w);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_basic();
      run_frame("basic_4x2", 4, 2, AW'('h100), 100, -1);
   endtask

   task automatic test_random_stall();
      run_frame("stall_128x64", 128, 64, AW'($urandom), 55, -1);
   endtask

   task automatic test_restart();
      run_frame("restart_5x3", 5, 3, AW'($urandom), 70, 6);
   endtask

   task automatic test_reset_mid_frame();
      int hs, cyc;
      hs = 0; cyc = 0;
      @(negedge Clk);
      CfgWidth = IW'(4); CfgHeight = HW'(4); CfgBaseAddr = AW'($urandom); Start = 1'b1;
      PxlRdyDrive(1'b1);
      @(negedge Clk);
      Start = 1'b0;
      while (hs < 5 && cyc < 50) begin
         if (pxl.PxlVld === 1'b1) hs++;
         if (hs < 5) begin
            @(negedge Clk);
            cyc++;
         end
      end
      checks++;
      if (hs != 5) begin
         failures++;
         $display("FAIL mid_reset_setup got %0d handshakes required 5", hs);
      end
      @(posedge Clk);
      #2;
      test_reset("mid_frame_reset");
      PxlRdyDrive(1'b0);
      run_frame("after_reset_2x2", 2, 2, AW'($urandom), 100, -1);
   endtask

   task automatic test_wrap();
      run_frame("wrap_1x3", 1, 3, {AW{1'b1}}, 100, -1);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++)
         run_frame($sformatf("rand_frame%0d", k), int'($urandom_range(1, 9)), int'($urandom_range(1, 5)),
                   AW'($urandom), int'($urandom_range(30, 100)), -1);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; pxl.PxlRdy = 1'b0;
      CfgWidth = '0; CfgHeight = '0; CfgBaseAddr = '0;
      #2;
      test_reset("power_on");
      test_basic();
      test_random_stall();
      test_zero_size("zero_width", 0, 5);
      test_zero_size("zero_height", 6, 0);
      test_restart();
      test_reset_mid_frame();
      test_wrap();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pxl_raster_tx.md
# pxl_raster_tx

Raster-scan pixel transmitter: on a start command it reads a stored image from a synchronous single-port memory and emits it pixel-by-pixel on the pixel stream interface consumed by the image resizer input (PxlData/PxlX/PxlY/ImgWidth/ImgHeight, PxlVld/PxlRdy). It is the producing end of that stream and replaces the behavioural driver used in simulation. A 2-entry prefetch buffer hides the 1-cycle memory read latency, so the stream sustains one pixel per cycle.

## Interface
- PXL_PRIM_COLOR_W, 8, bits per primary color
- PXL_PRIM_COLOR_NUM, 3, primary colors per pixel
- IMG_WIDTH_IDX_W, 11, width/X field width
- IMG_HEIGHT_IDX_W, 10, height/Y field width
- MEM_ADDR_W, 21, pixel memory word address width (one word = one pixel)

- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- Start  in  1  frame start pulse; accepted only when idle
- CfgWidth  in  IMG_WIDTH_IDX_W  pixels per line, sampled on accepted Start
- CfgHeight  in  IMG_HEIGHT_IDX_W  lines per frame, sampled on accepted Start
- CfgBaseAddr  in  MEM_ADDR_W  address of pixel (0,0), sampled on accepted Start
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse at frame end
- MemRdEn  out  1  memory read request
- MemRdAddr  out  MEM_ADDR_W  read address
- MemRdData  in  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  read data, valid exactly 1 cycle after MemRdEn; color 0 in LSBs
- ImgWidth  out  IMG_WIDTH_IDX_W  latched CfgWidth
- ImgHeight  out  IMG_HEIGHT_IDX_W  latched CfgHeight
- PxlData  out  PXL_PRIM_COLOR_NUM x PXL_PRIM_COLOR_W  unpacked array, element i = color i
- PxlX  out  IMG_WIDTH_IDX_W  column of current pixel
- PxlY  out  IMG_HEIGHT_IDX_W  row of current pixel
- PxlVld  out  1  pixel valid
- PxlRdy  in  1  downstream ready

## Operation
- FSM: IDLE -> RUN on Start; IDLE -> DONE on Start with CfgWidth==0 or CfgHeight==0; RUN -> DONE on handshake of last pixel (X==W-1, Y==H-1); DONE -> IDLE unconditionally.
- Start in RUN or DONE ignored, config not re-sampled.
- Read side: issue counters (rx, ry) and address counter starting at CfgBaseAddr; address +1 per read (address = base + y*W + x, no multiplier). Reads stop after pixel (W-1,H-1) is issued. Address wraps modulo 2^MEM_ADDR_W.
- Credit rule: read issued when occupancy + in-flight < 2, or == 2 with a pop (PxlVld & PxlRdy) in the same cycle. Buffer never overflows; MemRdData is always captured the cycle it is valid.
- Output side: PxlVld = buffer non-empty; PxlData = buffer head. Output counters (PxlX, PxlY) advance on handshake only: X+1; at X==W-1, X=0 and Y+1.
- While PxlVld=1 & PxlRdy=0: PxlData, PxlX, PxlY hold stable, PxlVld stays 1.
- ImgWidth/ImgHeight hold the latched values from accepted Start until the next accepted Start (stable for the whole frame).
- Busy = state != IDLE. Done = 1 in DONE only.

## Timing
- Reset (Reset=0): state IDLE, all counters 0, buffer empty, no read in flight; outputs Busy=0, Done=0, MemRdEn=0, MemRdAddr=0, PxlVld=0, PxlX=0, PxlY=0, PxlData=0, ImgWidth=0, ImgHeight=0. Reset mid-frame discards the frame; any read data returned after release is ignored.
- Start sampled at edge E0: cycle after E0 Busy=1, MemRdEn=1, MemRdAddr=base; data captured at next edge; PxlVld=1 in the 3rd cycle after E0 (latency 3).
- With PxlRdy held 1: one pixel per cycle, no bubbles, W*H consecutive PxlVld cycles.
- Last handshake at edge En: Done=1, Busy=1 in cycle after En; Busy=0, Done=0 the cycle after. Next Start accepted when Busy=0.
- Zero-size frame: Start at E0 -> Done=1 cycle after E0, no MemRdEn, no PxlVld.
- MemRdEn is 0 in IDLE and DONE.

## Test plan
- 4x2 frame, base=0x100, memory word = address, PxlRdy=1 -> 8 pixels back-to-back, (X,Y) = (0,0)..(3,0),(0,1)..(3,1), PxlData[0] = 0x00..0x07 low byte of 0x100..0x107, first PxlVld 3 cycles after Start, Done 1 cycle after last handshake.
- 128x64 frame with PxlRdy toggling pseudo-randomly -> 8192 pixels in order, outputs stable during every stall, buffer never captures >2, no read issued beyond 8192.
- CfgWidth=0 (and separately CfgHeight=0) -> Done pulse 1 cycle after Start, zero reads, zero PxlVld.
- Start re-pulsed mid-frame with different config -> ignored; ImgWidth/ImgHeight and pixel sequence unchanged.
- Reset asserted after 5 handshakes of a 4x4 frame -> all outputs reset values immediately; new 2x2 frame afterwards completes correctly with 4 pixels.
- 1xH frame (W=1, H=3), base=2^MEM_ADDR_W-1 -> X always 0, Y=0,1,2, addresses wrap to 0,1.
